// File: rtl/map_port_arbiter_if.sv
// Signal bundle between the map port arbiter, the VGA cell lookup, the game
// requesters and the single-port wall-map RAM.
interface map_port_arbiter_if;
   logic        i_vga_buzy;
   logic [5:0]  i_vga_x;
   logic [5:0]  i_vga_y;
   logic        o_vga_is_wall;
   logic [2:0]  i_req_valid;
   logic [2:0]  i_req_we;
   logic [17:0] i_req_x;
   logic [17:0] i_req_y;
   logic [2:0]  i_req_wdata;
   logic [2:0]  o_req_ready;
   logic [2:0]  o_rsp_valid;
   logic        o_rsp_rdata;
   logic [11:0] o_mem_addr;
   logic        o_mem_en;
   logic        o_mem_we;
   logic        o_mem_wdata;
   logic        i_mem_rdata;

   modport slave (
      input  i_vga_buzy, i_vga_x, i_vga_y,
      output o_vga_is_wall,
      input  i_req_valid, i_req_we, i_req_x, i_req_y, i_req_wdata,
      output o_req_ready, o_rsp_valid, o_rsp_rdata,
      output o_mem_addr, o_mem_en, o_mem_we, o_mem_wdata,
      input  i_mem_rdata
   );

   modport master (
      output i_vga_buzy, i_vga_x, i_vga_y,
      input  o_vga_is_wall,
      output i_req_valid, i_req_we, i_req_x, i_req_y, i_req_wdata,
      input  o_req_ready, o_rsp_valid, o_rsp_rdata,
      input  o_mem_addr, o_mem_en, o_mem_we, o_mem_wdata,
      output i_mem_rdata
   );
endinterface

// File: rtl/map_port_arbiter.sv
// Shares the wall-map RAM port: VGA lookups first, then round-robin among
// tank1, tank2 and the shell engine, with a fixed 3-cycle read latency.
module map_port_arbiter #(
   parameter int GRID_W              = 64,
   parameter int GAME_H              = 44,
   parameter bit WRITE_IN_BLANK_ONLY = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   map_port_arbiter_if.slave bus
);

   localparam int         XW      = $clog2(GRID_W);
   localparam logic [5:0] Y_LIMIT = 6'(GAME_H);
   localparam logic [1:0] SRC_VGA = 2'd3;

   function automatic logic [1:0] wrap3(logic [1:0] p, logic [1:0] k);
      logic [2:0] s;
      s = {1'b0, p} + {1'b0, k};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   logic [XW-1:0]    req_x [3];
   logic [5:0]       req_y [3];
   logic [2:0]       eligible;
   logic [2:0]       grant;
   logic [1:0]       grant_idx;
   logic             grant_any;
   logic [1:0]       rr_ptr;

   logic [XW+5:0]    vga_addr;
   logic [XW+5:0]    last_vga_addr;
   logic             vga_buzy_q;
   logic             vga_pend;

   logic             s1_valid;
   logic [XW+5:0]    s1_addr;
   logic             s1_we;
   logic             s1_wdata;
   logic [1:0]       s1_src;
   logic             s1_read;
   logic             s1_oob;

   logic             t1_valid, t1_read, t1_oob;
   logic [1:0]       t1_src;
   logic             t2_valid, t2_read, t2_oob;
   logic [1:0]       t2_src;

   logic [XW+5:0]    mem_addr_q;
   logic             mem_en_q, mem_we_q, mem_wdata_q;
   logic [2:0]       rsp_valid_q;
   logic             rsp_rdata_q;
   logic             vga_is_wall_q;

   assign vga_addr = {bus.i_vga_y, bus.i_vga_x[XW-1:0]};
   // A rising busy re-serves the current cell even if the address did not move.
   assign vga_pend = bus.i_vga_buzy & ((vga_addr != last_vga_addr) | ~vga_buzy_q);

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         req_x[i]    = bus.i_req_x[XW*i +: XW];
         req_y[i]    = bus.i_req_y[6*i +: 6];
         eligible[i] = bus.i_req_valid[i] &
                       (~bus.i_req_we[i] | ~(WRITE_IN_BLANK_ONLY & bus.i_vga_buzy));
      end
   end

   always_comb begin
      logic [1:0] cand;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      if (!vga_pend) begin
         for (int k = 0; k < 3; k++) begin
            cand = wrap3(rr_ptr, 2'(k));
            if (!grant_any && eligible[cand]) begin
               grant_any       = 1'b1;
               grant_idx       = cand;
               grant[cand]     = 1'b1;
            end
         end
      end
   end

   assign bus.o_req_ready = grant & {3{rst_n}};

   always_comb begin
      s1_valid = vga_pend | grant_any;
      s1_addr  = vga_addr;
      s1_we    = 1'b0;
      s1_wdata = 1'b0;
      s1_src   = SRC_VGA;
      s1_read  = 1'b1;
      s1_oob   = (bus.i_vga_y >= Y_LIMIT);
      if (!vga_pend) begin
         s1_addr  = {req_y[grant_idx], req_x[grant_idx]};
         s1_we    = bus.i_req_we[grant_idx];
         s1_wdata = bus.i_req_wdata[grant_idx];
         s1_src   = grant_idx;
         s1_read  = ~bus.i_req_we[grant_idx];
         s1_oob   = (req_y[grant_idx] >= Y_LIMIT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr        <= '0;
         last_vga_addr <= '0;
         vga_buzy_q    <= 1'b0;
         mem_addr_q    <= '0;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_wdata_q   <= 1'b0;
         t1_valid      <= 1'b0;
         t1_read       <= 1'b0;
         t1_oob        <= 1'b0;
         t1_src        <= '0;
         t2_valid      <= 1'b0;
         t2_read       <= 1'b0;
         t2_oob        <= 1'b0;
         t2_src        <= '0;
         rsp_valid_q   <= '0;
         rsp_rdata_q   <= 1'b0;
         vga_is_wall_q <= 1'b0;
      end else begin
         vga_buzy_q <= bus.i_vga_buzy;
         if (vga_pend)  last_vga_addr <= vga_addr;
         if (grant_any) rr_ptr        <= wrap3(grant_idx, 2'd1);

         // Out-of-range cells never touch the RAM; their reads resolve to wall.
         mem_en_q <= s1_valid & ~s1_oob;
         mem_we_q <= s1_valid & ~s1_oob & s1_we;
         if (s1_valid) begin
            mem_addr_q  <= s1_addr;
            mem_wdata_q <= s1_wdata;
         end

         t1_valid <= s1_valid;
         t1_read  <= s1_read;
         t1_oob   <= s1_oob;
         t1_src   <= s1_src;
         t2_valid <= t1_valid;
         t2_read  <= t1_read;
         t2_oob   <= t1_oob;
         t2_src   <= t1_src;

         rsp_valid_q <= '0;
         if (t2_valid && t2_read) begin
            if (t2_src == SRC_VGA) begin
               vga_is_wall_q <= t2_oob | bus.i_mem_rdata;
            end else begin
               rsp_valid_q <= 3'b001 << t2_src;
               rsp_rdata_q <= t2_oob | bus.i_mem_rdata;
            end
         end
      end
   end

   assign bus.o_mem_addr    = mem_addr_q;
   assign bus.o_mem_en      = mem_en_q;
   assign bus.o_mem_we      = mem_we_q;
   assign bus.o_mem_wdata   = mem_wdata_q;
   assign bus.o_rsp_valid   = rsp_valid_q;
   assign bus.o_rsp_rdata   = rsp_rdata_q;
   assign bus.o_vga_is_wall = vga_is_wall_q;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Randomized scoreboard bench for map_port_arbiter with a RAM model and a
// cell-level reference map.
module tb_map_port_arbiter;

   localparam int GAME_H = 44;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   map_port_arbiter_if bus();

   map_port_arbiter #(
      .GRID_W             (64),
      .GAME_H             (GAME_H),
      .WRITE_IN_BLANK_ONLY(1'b1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic init_bit(int a);
      return 1'(((a >> 1) ^ (a >> 3) ^ (a >> 4) ^ (a >> 9)) & 1);
   endfunction

   // Synchronous single-port RAM model.
   logic ram [4096];
   logic ram_rdata_q = 1'b0;
   bit   ram_ready   = 1'b0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int a = 0; a < 4096; a++) ram[a] <= init_bit(a);
         ram_ready <= 1'b1;
      end else if (bus.o_mem_en) begin
         if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
         else              ram_rdata_q         <= ram[bus.o_mem_addr];
      end
   end
   assign bus.i_mem_rdata = ram_rdata_q;

   // Reference model and scoreboard.
   typedef struct {
      int   src;
      logic data;
      int   due;
   } rsp_t;

   rsp_t        gq[$];
   rsp_t        vq[$];
   logic        ref_map [4096];
   bit          ref_ready = 1'b0;
   int          m_rr;
   logic [11:0] m_last_vga;
   logic        m_prev_buzy;
   logic        me_chk, me_acc, me_en, me_we, me_wd;
   logic [11:0] me_addr;

   always @(negedge clk) begin
      rsp_t        r;
      logic [2:0]  exp_ready;
      logic        acc;
      int          g;
      logic [5:0]  gx, gy;
      logic [11:0] vaddr;
      logic        vpend;
      if (!ref_ready) begin
         for (int a = 0; a < 4096; a++) ref_map[a] = init_bit(a);
         ref_ready = 1'b1;
      end
      if (!rst_n) begin
         check("rst_req_ready",   bus.o_req_ready,   0);
         check("rst_rsp_valid",   bus.o_rsp_valid,   0);
         check("rst_rsp_rdata",   bus.o_rsp_rdata,   0);
         check("rst_vga_is_wall", bus.o_vga_is_wall, 0);
         check("rst_mem_en",      bus.o_mem_en,      0);
         check("rst_mem_we",      bus.o_mem_we,      0);
         check("rst_mem_addr",    bus.o_mem_addr,    0);
         check("rst_mem_wdata",   bus.o_mem_wdata,   0);
         gq.delete();
         vq.delete();
         m_rr        = 0;
         m_last_vga  = '0;
         m_prev_buzy = 1'b0;
         me_chk      = 1'b0;
      end else begin
         if (me_chk) begin
            check("mem_en", bus.o_mem_en, me_en);
            check("mem_we", bus.o_mem_we, me_we);
            if (me_acc)        check("mem_addr",  bus.o_mem_addr,  me_addr);
            if (me_en && me_we) check("mem_wdata", bus.o_mem_wdata, me_wd);
         end

         if (bus.o_rsp_valid != 3'b000) begin
            if (gq.size() == 0) begin
               check("rsp_unexpected", bus.o_rsp_valid, 0);
            end else begin
               r = gq.pop_front();
               check("rsp_src",     bus.o_rsp_valid, 32'd1 << r.src);
               check("rsp_data",    bus.o_rsp_rdata, r.data);
               check("rsp_latency", cyc, r.due);
            end
         end else if (gq.size() != 0 && gq[0].due <= cyc) begin
            r = gq.pop_front();
            check("rsp_missing", bus.o_rsp_valid, 32'd1 << r.src);
         end

         if (vq.size() != 0 && vq[0].due == cyc) begin
            r = vq.pop_front();
            check("vga_is_wall", bus.o_vga_is_wall, r.data);
         end

         vaddr     = {bus.i_vga_y, bus.i_vga_x};
         vpend     = bus.i_vga_buzy && (vaddr != m_last_vga || !m_prev_buzy);
         exp_ready = 3'b000;
         acc       = 1'b0;
         g         = 0;
         me_en     = 1'b0;
         me_we     = 1'b0;
         me_wd     = 1'b0;
         if (vpend) begin
            m_last_vga = vaddr;
            r.src  = 3;
            r.data = (bus.i_vga_y >= GAME_H) ? 1'b1 : ref_map[vaddr];
            r.due  = cyc + 3;
            vq.push_back(r);
            acc     = 1'b1;
            me_en   = (bus.i_vga_y < GAME_H);
            me_addr = vaddr;
         end else begin
            for (int k = 0; k < 3; k++) begin
               int i;
               i = (m_rr + k) % 3;
               if (!acc && bus.i_req_valid[i] && (!bus.i_req_we[i] || !bus.i_vga_buzy)) begin
                  acc          = 1'b1;
                  g            = i;
                  exp_ready[i] = 1'b1;
               end
            end
            if (acc) begin
               m_rr    = (g + 1) % 3;
               gx      = bus.i_req_x[6*g +: 6];
               gy      = bus.i_req_y[6*g +: 6];
               me_addr = {gy, gx};
               me_en   = (gy < GAME_H);
               if (bus.i_req_we[g]) begin
                  me_we = me_en;
                  me_wd = bus.i_req_wdata[g];
                  if (gy < GAME_H) ref_map[{gy, gx}] = bus.i_req_wdata[g];
               end else begin
                  r.src  = g;
                  r.data = (gy >= GAME_H) ? 1'b1 : ref_map[{gy, gx}];
                  r.due  = cyc + 3;
                  gq.push_back(r);
               end
            end
         end
         check("req_ready", bus.o_req_ready, exp_ready);
         me_chk      = 1'b1;
         me_acc      = acc;
         m_prev_buzy = bus.i_vga_buzy;
      end
   end

   // Stimulus.
   logic [2:0] rv, rwe, rwd;
   logic [5:0] rx [3];
   logic [5:0] ry [3];
   logic [2:0] hs;

   task automatic apply();
      bus.i_req_valid = rv;
      bus.i_req_we    = rwe;
      bus.i_req_wdata = rwd;
      bus.i_req_x     = {rx[2], rx[1], rx[0]};
      bus.i_req_y     = {ry[2], ry[1], ry[0]};
   endtask

   task automatic set_req(int i, logic v, logic we, int x, int y, logic wd);
      rv[i]  = v;
      rwe[i] = we;
      rx[i]  = 6'(x);
      ry[i]  = 6'(y);
      rwd[i] = wd;
      apply();
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic tick();
      @(negedge clk);
      hs = bus.i_req_valid & bus.o_req_ready;
      @(posedge clk);
      #1;
   endtask

   int vxs [4];
   int vys [4];
   int oys [2];
   int ty;
   int vcnt;

   initial begin
      bus.i_vga_buzy = 1'b0;
      bus.i_vga_x    = '0;
      bus.i_vga_y    = '0;
      clear_reqs();

      // Reset held with toggling inputs.
      repeat (6) begin
         @(posedge clk);
         #1;
         bus.i_vga_buzy = 1'($urandom_range(0, 1));
         bus.i_vga_x    = 6'($urandom_range(0, 63));
         bus.i_vga_y    = 6'($urandom_range(0, 63));
         for (int i = 0; i < 3; i++)
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 63),
                    $urandom_range(0, 63), 1'($urandom_range(0, 1)));
      end
      bus.i_vga_buzy = 1'b0;
      bus.i_vga_x    = '0;
      bus.i_vga_y    = '0;
      clear_reqs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) tick();

      // Round-robin with all three reads held valid.
      for (int i = 0; i < 3; i++)
         set_req(i, 1'b1, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
      for (int n = 0; n < 12; n++) begin
         tick();
         check("rr_order", hs, 32'd1 << (n % 3));
         for (int i = 0; i < 3; i++)
            if (hs[i]) set_req(i, 1'b1, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
      end
      clear_reqs();
      repeat (5) tick();

      // VGA priority: tank1 stalls exactly on lookup cycles.
      vxs = '{9, 33, 0, 62};
      vys = '{3, 20, 45, 10};
      set_req(0, 1'b1, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
      for (int n = 0; n < 40; n++) begin
         if (n % 10 == 0) begin
            bus.i_vga_buzy = 1'b1;
            bus.i_vga_x    = 6'(vxs[n / 10]);
            bus.i_vga_y    = 6'(vys[n / 10]);
         end
         tick();
         check("vga_stall", hs[0], (n % 10 == 0) ? 0 : 1);
         if (hs[0]) set_req(0, 1'b1, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
      end
      clear_reqs();
      repeat (4) tick();

      // Shell write held during busy, granted when busy falls.
      set_req(2, 1'b1, 1'b1, 5, 7, 1'b1);
      repeat (6) begin
         tick();
         check("write_blocked", hs[2], 0);
      end
      bus.i_vga_buzy = 1'b0;
      tick();
      check("write_grant", hs, 3'b100);
      check("write_mem_addr", bus.o_mem_addr, 12'h1C5);
      check("write_mem_we", bus.o_mem_we, 1);
      clear_reqs();
      set_req(0, 1'b1, 1'b0, 5, 7, 1'b0);
      tick();
      check("readback_grant", hs, 3'b001);
      clear_reqs();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("readback_valid", bus.o_rsp_valid, 3'b001);
      check("readback_data", bus.o_rsp_rdata, 1);

      // Out-of-range reads and write.
      oys = '{44, 63};
      for (int k = 0; k < 2; k++) begin
         set_req(1, 1'b1, 1'b0, 3, oys[k], 1'b0);
         tick();
         check("oob_grant", hs, 3'b010);
         check("oob_mem_en", bus.o_mem_en, 0);
         clear_reqs();
         @(posedge clk);
         @(posedge clk);
         #1;
         check("oob_rsp_valid", bus.o_rsp_valid, 3'b010);
         check("oob_rsp_data", bus.o_rsp_rdata, 1);
      end
      set_req(1, 1'b1, 1'b1, 3, 50, ~init_bit({6'd50, 6'd3}));
      tick();
      check("oob_write_grant", hs, 3'b010);
      check("oob_write_mem_en", bus.o_mem_en, 0);
      clear_reqs();
      repeat (3) tick();
      check("oob_write_ram", ram[{6'd50, 6'd3}], init_bit({6'd50, 6'd3}));

      // Reset in flight: no response, pointer back to requester 0.
      set_req(1, 1'b1, 1'b0, 4, 4, 1'b0);
      tick();
      check("flight_grant", hs, 3'b010);
      rst_n = 1'b0;
      clear_reqs();
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, i + 1, 2, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check("post_reset_first", hs, 3'b001);
      clear_reqs();
      repeat (6) tick();

      // Randomized traffic.
      vcnt = 0;
      for (int n = 0; n < 800; n++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            if (hs[i] || !rv[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  if ($urandom_range(0, 7) == 0) ty = $urandom_range(44, 63);
                  else                           ty = $urandom_range(0, 7);
                  set_req(i, 1'b1, ($urandom_range(0, 2) == 0), $urandom_range(0, 7), ty,
                          1'($urandom_range(0, 1)));
               end else begin
                  set_req(i, 1'b0, 1'b0, 0, 0, 1'b0);
               end
            end
         end
         if ($urandom_range(0, 24) == 0) bus.i_vga_buzy = ~bus.i_vga_buzy;
         vcnt++;
         if (bus.i_vga_buzy && vcnt >= 10 && $urandom_range(0, 3) == 0) begin
            bus.i_vga_x = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) bus.i_vga_y = 6'($urandom_range(44, 63));
            else                           bus.i_vga_y = 6'($urandom_range(0, 7));
            vcnt = 0;
         end
      end
      clear_reqs();
      bus.i_vga_buzy = 1'b0;
      repeat (8) tick();
      check("drain_game_queue", gq.size(), 0);
      check("drain_vga_queue", vq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
